// File: rtl/microrv32_bus_arbiter.sv
// Two-master round-robin arbiter for the MicroRV32 shared bus.
// Serialises CPU (m0) and debug/loader (m1) transactions onto one slave port, with timeout error.
module microrv32_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  output logic                m0_err,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                m1_err,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic [1:0]          grant
);

  localparam int unsigned   STRB_W   = DATA_W / 8;
  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [7:0]          r_cnt;

  logic                w_req_any;
  logic                w_pick;
  logic                w_timeout;

  assign w_req_any = m0_valid | m1_valid;
  // On a tie the master that did not win last time is chosen.
  assign w_pick    = (m0_valid && m1_valid) ? ~r_last : m1_valid;
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_any) w_next = ST_BUSY;
      ST_BUSY: if (s_ready || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_addr  <= w_pick ? m1_addr  : m0_addr;
            r_wdata <= w_pick ? m1_wdata : m0_wdata;
            r_wstrb <= w_pick ? m1_wstrb : m0_wstrb;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          // s_ready takes priority over an expiring timeout in the same cycle.
          if (s_ready) begin
            r_rdata <= s_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    grant    = 2'b00;
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (r_state)
      ST_BUSY: begin
        s_valid = 1'b1;
        s_addr  = r_addr;
        s_wdata = r_wdata;
        s_wstrb = r_wstrb;
        grant   = r_owner ? 2'b10 : 2'b01;
      end
      ST_RESP: begin
        grant = r_owner ? 2'b10 : 2'b01;
        if (r_owner) begin
          m1_ready = 1'b1;
          m1_err   = r_err;
          m1_rdata = r_rdata;
        end else begin
          m0_ready = 1'b1;
          m0_err   = r_err;
          m0_rdata = r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_microrv32_bus_arbiter.sv
// Randomized transaction-level bench for microrv32_bus_arbiter (TIMEOUT=8).
// Expected grant order, forwarded fields, latency and response come from a round-robin transaction model.
module tb_microrv32_bus_arbiter;

  localparam int unsigned TO = 8;
  localparam int unsigned NR = 80;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready, m0_err, m1_err;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [1:0]  grant;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: pending requests per master and last winner.
  logic        p [2];
  logic [31:0] a [2];
  logic [31:0] wd[2];
  logic [3:0]  ws[2];
  int unsigned last_w;

  microrv32_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int unsigned m, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] st);
    p[m]  = 1'b1;
    a[m]  = ad;
    wd[m] = d;
    ws[m] = st;
  endtask

  task automatic drive();
    m0_valid = p[0]; m0_addr = a[0]; m0_wdata = wd[0]; m0_wstrb = ws[0];
    m1_valid = p[1]; m1_addr = a[1]; m1_wdata = wd[1]; m1_wstrb = ws[1];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_sval"},  s_valid,  1'b0);
    chk({tag, "_m0rdy"}, m0_ready, 1'b0);
    chk({tag, "_m1rdy"}, m1_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned w, d, k;
    logic [31:0] data, exp_rd;
    logic        exp_err, abort;

    for (int i = 0; i < 2; i++) begin
      p[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0;
    end
    last_w  = 1;
    rstn    = 1'b0;
    s_ready = 1'b0;
    s_rdata = '0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0err", m0_err, 1'b0);
    chk("rst_m0rd", m0_rdata, 32'h0);
    chk("rst_saddr", s_addr, 32'h0);

    // Both masters request together out of reset: m0 must win first.
    rstn = 1'b1;
    new_req(0, 32'h0000_0100, 32'h0, 4'b0000);
    new_req(1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    drive();

    for (int unsigned r = 0; r < NR; r++) begin
      if (!p[0] && !p[1]) begin
        k = $urandom_range(0, 3);
        repeat (k) begin
          @(negedge clk);
          chk("idle_sval", s_valid, 1'b0);
          chk("idle_grant", grant, 2'b00);
          s_ready = 1'($urandom_range(0, 1));
        end
        case ($urandom_range(0, 2))
          0:       new_req(0, $urandom, $urandom, 4'($urandom));
          1:       new_req(1, $urandom, $urandom, 4'($urandom));
          default: begin
            new_req(0, $urandom, $urandom, 4'($urandom));
            new_req(1, $urandom, $urandom, 4'($urandom));
          end
        endcase
        drive();
      end

      k = 0;
      while (!s_valid && k < 4) begin
        @(negedge clk);
        k++;
        if (!s_valid) s_ready = 1'($urandom_range(0, 1));
      end
      chk("issue_lat", k, 1);
      if (!s_valid) begin
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end

      w      = (p[0] && p[1]) ? (last_w == 0 ? 1 : 0) : (p[1] ? 1 : 0);
      last_w = w;
      d      = $urandom_range(0, TO + 1);
      data   = $urandom;
      if (r == 0) d = 2;
      if (r == 1) d = 0;
      if (r == 2) d = TO;
      if (r == 3) d = TO - 1;
      abort  = (r % 17 == 9);

      for (int unsigned c = 0; ; c++) begin
        chk("busy_sval",  s_valid, 1'b1);
        chk("busy_grant", grant, (w == 1) ? 2'b10 : 2'b01);
        chk("busy_addr",  s_addr,  a[w]);
        chk("busy_wdata", s_wdata, wd[w]);
        chk("busy_wstrb", s_wstrb, ws[w]);
        chk("busy_m0rdy", m0_ready, 1'b0);
        chk("busy_m1rdy", m1_ready, 1'b0);
        s_ready = !abort && (c == d);
        s_rdata = (c == d) ? data : $urandom;
        if (w == 0) begin m1_addr = $urandom; m1_wdata = $urandom; end
        @(posedge clk);
        if (abort && c == 1) break;
        if (!abort && (c == d || c == TO - 1)) break;
        @(negedge clk);
      end

      if (abort) begin
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_grant", grant, 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk_quiet("abort_hold");
        rstn   = 1'b1;
        last_w = 1;
        if (!p[0]) new_req(0, $urandom, $urandom, 4'($urandom));
        if (!p[1]) new_req(1, $urandom, $urandom, 4'($urandom));
        drive();
        continue;
      end

      drive();
      exp_err = (d >= TO);
      exp_rd  = exp_err ? 32'h0 : data;
      @(negedge clk);
      s_ready = exp_err ? 1'($urandom_range(0, 1)) : 1'b0;
      s_rdata = $urandom;
      chk("resp_sval",  s_valid, 1'b0);
      chk("resp_m0rdy", m0_ready, w == 0);
      chk("resp_m1rdy", m1_ready, w == 1);
      chk("resp_m0err", m0_err,   (w == 0) && exp_err);
      chk("resp_m1err", m1_err,   (w == 1) && exp_err);
      chk("resp_m0rd",  m0_rdata, (w == 0) ? exp_rd : 32'h0);
      chk("resp_m1rd",  m1_rdata, (w == 1) ? exp_rd : 32'h0);

      p[w] = 1'b0;
      if ($urandom_range(0, 3) != 0) new_req(w, $urandom, $urandom, 4'($urandom));
      drive();
      @(negedge clk);
      chk_quiet("post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
